// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line and received-byte handshake bundle for uart_receiver
// master: drives uart_rx/data_taken, reads have_new_data/new_data/framing_error/overrun_error
// slave:  the receiver side (directions reversed)
interface uart_receiver_if;
  logic uart_rx;
  logic data_taken;
  logic have_new_data;
  logic [7:0] new_data;
  logic framing_error;
  logic overrun_error;
  modport master(output uart_rx, data_taken, input have_new_data, new_data, framing_error, overrun_error);
  modport slave(input uart_rx, data_taken, output have_new_data, new_data, framing_error, overrun_error);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with mid-bit sampling, one-entry holding register and error pulses
// clk, rst (sync, active-high); bus (slave): uart_rx, data_taken in;
// have_new_data, new_data[7:0], framing_error, overrun_error out
module uart_receiver #(
  parameter int BAUD_RATE = 115200,
  parameter int CLOCK_RATE = 25_000_000
) (
  input logic clk,
  input logic rst,
  uart_receiver_if.slave bus
);
  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);
  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] STOP = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [1:0] sync;
  logic rxs;
  assign rxs = sync[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      state <= WAIT_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      bus.have_new_data <= 1'b0;
      bus.new_data <= '0;
      bus.framing_error <= 1'b0;
      bus.overrun_error <= 1'b0;
    end else begin
      sync <= {sync[0], bus.uart_rx};
      bus.framing_error <= 1'b0;
      bus.overrun_error <= 1'b0;
      cnt <= cnt + 1'b1;
      if (bus.data_taken) bus.have_new_data <= 1'b0;
      case (state)
        WAIT_IDLE: if (rxs) begin
          state <= IDLE;
          cnt <= '0;
        end
        IDLE: if (!rxs) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == HALF_END) begin
          state <= rxs ? IDLE : DATA;
          cnt <= '0;
          bit_idx <= '0;
        end
        DATA: if (cnt == BIT_END) begin
          shift <= {rxs, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
          cnt <= '0;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (cnt == BIT_END) begin
          state <= rxs ? IDLE : WAIT_IDLE;
          cnt <= '0;
          bus.framing_error <= !rxs;
          // a pop in the same cycle frees the register for the incoming byte
          if (rxs && (!bus.have_new_data || bus.data_taken)) begin
            bus.new_data <= shift;
            bus.have_new_data <= 1'b1;
          end
          bus.overrun_error <= rxs && bus.have_new_data && !bus.data_taken;
        end
        default: begin
          state <= WAIT_IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule
